// File: rtl/alu_resp.sv
// alu_resp: registered ALU responder with valid/ready on both sides.
// Requests are evaluated combinationally and the result is pushed into a
// small result FIFO. The consumer pops results from the FIFO head.
// Optional feature macro: ALU_RESP_FLAGS_EN (carry/zero storage and outputs).
// Without the macro, carry and zero are tied low and no flag storage exists.
module alu_resp #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [1:0]       opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic [7:0]       txn_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } occ_e;

  occ_e             state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       txn_cnt_q, txn_cnt_d;

  logic [WIDTH-1:0] y_mem_q [DEPTH];
  logic [WIDTH-1:0] y_mem_d [DEPTH];

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] alu_y;

`ifdef ALU_RESP_FLAGS_EN
  logic             alu_carry;
  logic             alu_zero;
  logic [DEPTH-1:0] carry_mem_q, carry_mem_d;
  logic [DEPTH-1:0] zero_mem_q, zero_mem_d;
`endif

  // ALU: evaluate the current request; only used when the request is accepted
  always_comb begin
    alu_y = '0;
`ifdef ALU_RESP_FLAGS_EN
    alu_carry = 1'b0;
`endif
    case (opcode)
      2'b00: begin
`ifdef ALU_RESP_FLAGS_EN
        {alu_carry, alu_y} = {1'b0, op1} + {1'b0, op2};
`else
        alu_y = op1 + op2;
`endif
      end
      2'b01: begin
`ifdef ALU_RESP_FLAGS_EN
        // the extra top bit of the widened difference is the unsigned borrow
        {alu_carry, alu_y} = {1'b0, op1} - {1'b0, op2};
`else
        alu_y = op1 - op2;
`endif
      end
      2'b10:   alu_y = op1 & op2;
      default: alu_y = op1 ^ op2;
    endcase
`ifdef ALU_RESP_FLAGS_EN
    alu_zero = (alu_y == '0);
`endif
  end

  // handshakes: req_ready looks only at registered state plus reset, so no
  // path exists from rsp_ready back to req_ready
  assign req_ready = (state_q != S_FULL) && !rst;
  assign rsp_valid = (state_q != S_EMPTY);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign txn_cnt   = txn_cnt_q;

  // next-state logic for occupancy FSM, pointers, count and transaction counter
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    txn_cnt_d = txn_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      txn_cnt_d = txn_cnt_q + 8'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        if (push && !pop && (count_q == CNT_FULL - CNT_ONE)) begin
          state_d = S_FULL;
        end else if (pop && !push && (count_q == CNT_ONE)) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_PARTIAL;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // control registers with synchronous reset; reset drops any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      txn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  // storage write: the tail entry takes the ALU result when a request is accepted
  always_comb begin
    y_mem_d = y_mem_q;
`ifdef ALU_RESP_FLAGS_EN
    carry_mem_d = carry_mem_q;
    zero_mem_d  = zero_mem_q;
`endif
    if (push) begin
      y_mem_d[wr_ptr_q] = alu_y;
`ifdef ALU_RESP_FLAGS_EN
      carry_mem_d[wr_ptr_q] = alu_carry;
      zero_mem_d[wr_ptr_q]  = alu_zero;
`endif
    end
  end

  // storage registers need no reset: stale entries are masked while empty
  always_ff @(posedge clk) begin
    y_mem_q <= y_mem_d;
`ifdef ALU_RESP_FLAGS_EN
    carry_mem_q <= carry_mem_d;
    zero_mem_q  <= zero_mem_d;
`endif
  end

  // outputs show the FIFO head, forced to zero when nothing is queued
  always_comb begin
    y     = '0;
    carry = 1'b0;
    zero  = 1'b0;
    if (rsp_valid) begin
      y = y_mem_q[rd_ptr_q];
`ifdef ALU_RESP_FLAGS_EN
      carry = carry_mem_q[rd_ptr_q];
      zero  = zero_mem_q[rd_ptr_q];
`endif
    end
  end

endmodule

// File: tb/tb_alu_resp.sv
// Testbench for alu_resp: randomized and directed stimulus, scoreboard checking.
// Honours ALU_RESP_FLAGS_EN when deciding the expected carry/zero values.
module tb_alu_resp;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] op1 = '0;
  logic [WIDTH-1:0] op2 = '0;
  logic [1:0]       opcode = 2'b00;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             zero;
  logic [7:0]       txn_cnt;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             z;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_txn = 8'd0;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         rand_done = 1'b0;

  alu_resp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op1       (op1),
    .op2       (op2),
    .opcode    (opcode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .txn_cnt   (txn_cnt)
  );

  // free-running clock
  always #5 clk = ~clk;

  // one comparison: counts it and reports any difference
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // reference ALU built from plain integer arithmetic
  function automatic exp_t refModel(input int a, input int b, input int op);
    exp_t e;
    int   m;
    int   r;
    m = 1 << WIDTH;
    e.c = 1'b0;
    case (op)
      0: begin
        r = a + b;
        e.c = (r >= m);
        r = r % m;
      end
      1: begin
        e.c = (a < b);
        r = (a - b + m) % m;
      end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    e.y = WIDTH'(r);
    e.z = (r == 0);
`ifndef ALU_RESP_FLAGS_EN
    e.c = 1'b0;
    e.z = 1'b0;
`endif
    return e;
  endfunction

  // present one request and hold it until accepted; expected result queued on acceptance
  task automatic applyStimulus(input int a, input int b, input int op);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    req_valid = 1'b1;
    op1 = WIDTH'(a);
    op2 = WIDTH'(b);
    opcode = 2'(op);
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = req_ready && !rst;
      @(posedge clk);
      #1;
      waited++;
    end
    if (acc) begin
      exp_q.push_back(refModel(a, b, op));
    end else begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no req_ready, expected acceptance within 200 cycles");
      req_valid = 1'b0;
    end
  endtask

  task automatic endRequests();
    req_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: compares handshake state, txn count and head result against the model
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checkOutput("req_ready_in_reset", int'(req_ready), 0);
      exp_q.delete();
      exp_txn = 8'd0;
    end else begin
      checkOutput("rsp_valid", int'(rsp_valid), int'(exp_q.size() != 0));
      checkOutput("req_ready", int'(req_ready), int'(exp_q.size() != DEPTH));
      checkOutput("txn_cnt", int'(txn_cnt), int'(exp_txn));
      if (exp_q.size() == 0) begin
        checkOutput("y_empty", int'(y), 0);
        checkOutput("carry_empty", int'(carry), 0);
        checkOutput("zero_empty", int'(zero), 0);
      end else begin
        e = exp_q[0];
        checkOutput("y_head", int'(y), int'(e.y));
        checkOutput("carry_head", int'(carry), int'(e.c));
        checkOutput("zero_head", int'(zero), int'(e.z));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          exp_txn = exp_txn + 8'd1;
        end
      end
    end
  end

  initial begin
    logic [7:0] base;

    // post-reset idle
    rst = 1'b1;
    idleCycles(2);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("req_ready_after_reset", int'(req_ready), 1);
    idleCycles(1);

    // four opcodes back-to-back with consumer always ready
    rsp_ready = 1'b1;
    applyStimulus(5, 8, 0);
    applyStimulus(10, 8, 1);
    applyStimulus(10, 8, 2);
    applyStimulus(10, 8, 3);
    endRequests();
    idleCycles(2);
    @(negedge clk);
    checkOutput("txn_after_opcodes", int'(txn_cnt), 4);
    idleCycles(1);

    // flag edge cases: sum overflow to zero, subtract with borrow
    applyStimulus(15, 1, 0);
    applyStimulus(3, 5, 1);
    endRequests();
    idleCycles(2);

    // back-pressure: third request stalls until the consumer drains
    rsp_ready = 1'b0;
    applyStimulus(1, 2, 0);
    applyStimulus(7, 3, 1);
    fork
      applyStimulus(6, 5, 3);
      begin
        idleCycles(4);
        rsp_ready = 1'b1;
      end
    join
    endRequests();
    idleCycles(4);

    // simultaneous push/pop holding occupancy at one
    rsp_ready = 1'b0;
    applyStimulus(9, 9, 2);
    rsp_ready = 1'b1;
    base = exp_txn;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end
    endRequests();
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("txn_after_pushpop", int'(txn_cnt), int'(base + 8'd10));
    checkOutput("occupancy_one", int'(rsp_valid), 1);
    idleCycles(1);
    rsp_ready = 1'b1;
    idleCycles(2);

    // randomized traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
          if ($urandom_range(0, 3) == 0) begin
            endRequests();
            idleCycles(int'($urandom_range(1, 3)));
          end
        end
        endRequests();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rsp_ready = ($urandom_range(0, 2) != 0);
          idleCycles(1);
        end
      end
    join
    rsp_ready = 1'b1;
    idleCycles(4);

    // reset while full discards queued results
    rsp_ready = 1'b0;
    applyStimulus(2, 2, 0);
    applyStimulus(4, 4, 0);
    endRequests();
    idleCycles(1);
    rsp_ready = 1'b1;
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rsp_valid_after_midreset", int'(rsp_valid), 0);
    checkOutput("txn_after_midreset", int'(txn_cnt), 0);
    idleCycles(3);

    // counter wrap: 257 responses
    for (int i = 0; i < 257; i++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end
    endRequests();
    idleCycles(3);
    @(negedge clk);
    checkOutput("txn_wrap", int'(txn_cnt), 1);
    idleCycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_resp.md
# alu_resp

Registered ALU responder with valid/ready handshakes on both sides. It accepts operand/opcode requests, computes a WIDTH-bit result, and queues results in a small FIFO until the consumer takes them. It sits between an operand source (sequencer or testbench driver) and a result consumer, and replaces direct combinational ALU hookup wherever back-pressure is needed.

## Interface
Parameters:
- WIDTH, 4: operand and result width in bits.
- DEPTH, 2: result FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- op1  input  WIDTH  first operand
- op2  input  WIDTH  second operand
- opcode  input  2  operation select
- rsp_valid  output  1  result at FIFO head is valid
- rsp_ready  input  1  consumer takes the head result this cycle
- y  output  WIDTH  result
- carry  output  1  carry/borrow flag
- zero  output  1  result-is-zero flag
- txn_cnt  output  8  count of completed responses, wraps 255→0

## Operation
- Opcodes:
  - 00: y = op1+op2 mod 2^WIDTH, carry = bit WIDTH of the sum.
  - 01: y = op1−op2 mod 2^WIDTH, carry = 1 iff op1 < op2 (unsigned borrow).
  - 10: y = op1 & op2, carry = 0.
  - 11: y = op1 ^ op2, carry = 0.
- zero = (y == 0) for every opcode.
- Request accepted (push) when req_valid && req_ready. The result and flags are computed combinationally from the inputs in that cycle and written into the FIFO tail.
- Response completes (pop) when rsp_valid && rsp_ready. The head is removed and txn_cnt increments by 1 (mod 256).
- req_ready = (count != DEPTH) and not rst.
- rsp_valid = (count != 0).
- y/carry/zero always show the FIFO head. They are forced to 0 when count == 0.
- Occupancy state:
  - EMPTY (count 0).
  - PARTIAL (0 < count < DEPTH).
  - FULL (count == DEPTH).
- Transitions:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle: count unchanged. Allowed in PARTIAL. In EMPTY the push lands and no pop occurs, because rsp_valid is 0.
  - In FULL, req_ready is 0, so no push can occur. A pop moves the state to PARTIAL.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. Order is strictly FIFO.
- Inputs op1/op2/opcode are ignored when req_valid = 0 or req_ready = 0.

## Timing
- Latency: a request accepted at edge N gives rsp_valid = 1 after edge N (the next cycle) if the FIFO was empty. There is no combinational path from request inputs to rsp_* outputs.
- No combinational path from rsp_ready to req_ready. req_ready depends only on registered count.
- Throughput: one request per cycle is sustained while rsp_ready stays high.
- Reset (rst high at an edge): count = 0, pointers = 0, txn_cnt = 0. All queued results are discarded.
- Output values after reset:
  - rsp_valid = 0; y = 0, carry = 0, zero = 0.
  - req_ready = 0 while rst is high, and 1 in the first cycle after rst drops.
- Reset mid-operation: a push or pop in the same cycle as rst is dropped, and txn_cnt does not increment.
- Consumer rule: the consumer may hold rsp_ready high indefinitely. The producer must keep req_valid and its data stable until accepted. The responder does not check this.

## Configuration
- ALU_RESP_FLAGS_EN:
  - Defined: carry and zero are computed, stored per FIFO entry, and driven as specified.
  - Undefined: flag storage is omitted, and carry and zero are tied to 0. Ports remain, so instantiations are unchanged.

## Test plan
- Post-reset idle: hold rst 2 cycles, then release. Required: req_ready = 0 during reset and 1 after, rsp_valid = 0, y = 0, txn_cnt = 0.
- Four opcodes, rsp_ready = 1, WIDTH = 4: send (5,8,00), (a,8,01), (a,8,10), (a,8,11) back-to-back. Required: y = d, 2, 8, 2 in order, each one cycle after its request. With flags enabled: carry = 0,0,0,0 and zero = 0 throughout. Final txn_cnt = 4.
- Flag edges: send (f,1,00) and (3,5,01). Required: y = 0 with carry = 1 and zero = 1; then y = e with carry = 1 and zero = 0. With the macro undefined, carry = zero = 0.
- Back-pressure: rsp_ready = 0, send 3 requests. Required: the first 2 are accepted, then req_ready = 0 (FULL). Raise rsp_ready and require in-order drain with no loss or duplication.
- Simultaneous push/pop: with count = 1, drive req and rsp together for 10 cycles. Required: count stays 1, results stay in order, txn_cnt increases by 10.
- Mid-operation reset: fill to FULL, then assert rst for 1 cycle with rsp_ready = 1. Required: rsp_valid = 0 and txn_cnt = 0 after the edge, and the old results never appear afterward.
- Wrap: perform 257 responses. Required: txn_cnt = 1.
